bin2bcd_feeder: RTL and testbench



---
 rtl/display_pkg.sv | 35 +++
 rtl/add3_digit.sv | 19 +
 rtl/bin2bcd_feeder.sv | 141 ++++++++++++++
 tb/tb_bin2bcd_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the seven-segment display path
//               (binary-to-BCD feeder and display driver).
//               Contents:
//                 state_t        - feeder FSM states (IDLE, CONVERT)
//                 DISPLAY_DIGITS - number of decimal digits on the display
//                 BCD_SAT        - packed BCD value with every digit at nine
//                 bcd_limit()    - largest value representable in N digits
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int DISPLAY_DIGITS = 8;

  localparam logic [4*DISPLAY_DIGITS-1:0] BCD_SAT = {DISPLAY_DIGITS{4'h9}};

  // 10^digits - 1, evaluated at elaboration time for the overflow compare.
  function automatic longint unsigned bcd_limit(input int unsigned digits);
    longint unsigned v;
    v = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add3_digit.sv
`default_nettype none
// ============================================================================
// Module      : add3_digit
// Description : Double-dabble digit correction. A BCD digit of 5 or more is
//               bumped by 3 so that the following left shift carries into the
//               next decimal digit instead of producing a hex digit.
// Ports       : i_digit [3:0] - BCD digit before correction
//               o_digit [3:0] - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module add3_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_feeder.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_feeder
// Description : Sequential binary to packed-BCD converter (shift-and-add-3),
//               one bit per clock. Feeds the 8-digit seven-segment driver.
//               Inputs above 10^DIGITS-1 saturate to all nines with overflow.
// Ports       : clock    - system clock, rising edge
//               reset_n  - asynchronous active-low reset
//               bin_in   - unsigned binary value, sampled on accept
//               in_valid - bin_in valid
//               in_ready - idle, accepts on this edge
//               bcd_out  - packed BCD, digit 0 in [3:0], held between results
//               done     - one-cycle pulse when bcd_out updates
//               overflow - last input exceeded 10^DIGITS-1
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_feeder
  import display_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = DISPLAY_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  overflow
);

  localparam int                    c_cnt_w = $clog2(BIN_W);
  localparam logic [c_cnt_w-1:0]    c_last  = c_cnt_w'(BIN_W - 1);
  localparam logic [63:0]           c_limit = 64'(bcd_limit(DIGITS));
  localparam logic [4*DIGITS-1:0]   c_sat   = {DIGITS{4'h9}};

  state_t                r_state;
  state_t                w_state_next;
  logic [BIN_W-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_ovf_pending;
  logic [4*DIGITS-1:0]   r_bcd_out;
  logic                  r_done;
  logic                  r_overflow;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_ovf;
  logic                  w_sat;
  logic [4*DIGITS-1:0]   w_bcd_adj;
  logic [4*DIGITS-1:0]   w_bcd_next;
  logic [BIN_W-1:0]      w_bin_next;

  // Per-digit add-3 correction on the accumulator before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    add3_digit u_add3 (
      .i_digit (r_bcd[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  // {bcd, bin} shifted left by one as a single concatenation.
  assign w_bcd_next = {w_bcd_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};
  assign w_bin_next = {r_bin[BIN_W-2:0], 1'b0};

  assign w_ovf = (64'(bin_in) > c_limit);

  // A bit falling off the top of the accumulator can only happen for an
  // out-of-range input, so it is folded into the saturate decision.
  assign w_sat = r_ovf_pending | w_bcd_adj[4*DIGITS-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (r_count == c_last) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bin         <= '0;
      r_bcd         <= '0;
      r_count       <= '0;
      r_ovf_pending <= 1'b0;
      r_bcd_out     <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bin         <= bin_in;
        r_bcd         <= '0;
        r_count       <= '0;
        r_ovf_pending <= w_ovf;
      end else if (r_state == CONVERT) begin
        r_bin   <= w_bin_next;
        r_bcd   <= w_bcd_next;
        r_count <= r_count + c_cnt_w'(1);
        if (w_last) begin
          r_bcd_out  <= w_sat ? c_sat : w_bcd_next;
          r_overflow <= r_ovf_pending;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign in_ready = w_in_ready;
  assign bcd_out  = r_bcd_out;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_feeder
// Description : Self-checking bench for bin2bcd_feeder. Expected results come
//               from a decimal reference model (divide/modulo by ten).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_feeder;
  import display_pkg::*;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int LAT    = BIN_W;

  logic                clock;
  logic                reset_n;
  logic [BIN_W-1:0]    bin_in;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic                done;
  logic                overflow;

  int errors = 0;
  int checks = 0;

  bin2bcd_feeder #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bin_in   (bin_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_out  (bcd_out),
    .done     (done),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal reference: peel off digits with /10 and %10, saturate above range.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0]  r;
    int unsigned  x;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block idle: present v, let it be accepted,
  // then scramble bin_in to show it is not resampled.
  task automatic start(input int unsigned v);
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    bin_in   = BIN_W'(v);
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    bin_in   = BIN_W'($urandom);
    chk("busy_after_accept", 64'(in_ready), 64'd0);
    chk("done_low_after_accept", 64'(done), 64'd0);
  endtask

  // Called at the negedge just after the accept edge; returns at the negedge
  // where done is seen (block idle again there).
  task automatic wait_done(input int unsigned v);
    int k;
    k = 0;
    while (!done && k < LAT + 10) begin
      @(negedge clock);
      k++;
    end
    chk("latency", 64'(k), 64'(LAT));
    chk("bcd_out", 64'(bcd_out), 64'(ref_bcd(v)));
    chk("overflow", 64'(overflow), 64'(v > 32'd99_999_999));
    chk("ready_at_done", 64'(in_ready), 64'd1);
  endtask

  task automatic convert(input int unsigned v);
    start(v);
    wait_done(v);
  endtask

  initial begin
    int seen;
    int unsigned v;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clock);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_bcd", 64'(bcd_out), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // Main example and boundaries.
    convert(12_345_678);
    @(negedge clock);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("bcd_held", 64'(bcd_out), 64'h1234_5678);
    convert(0);
    convert(99_999_999);
    convert(100_000_000);
    convert((1 << BIN_W) - 1);
    chk("sat_const", 64'(bcd_out), 64'(BCD_SAT));
    convert(5);

    // Busy-ignore: 7 presented throughout the conversion of 42.
    @(negedge clock);
    chk("ready_idle", 64'(in_ready), 64'd1);
    bin_in   = BIN_W'(42);
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bin_in = BIN_W'(7);
    for (int i = 0; i < 10; i++) begin
      chk("ready_low_busy", 64'(in_ready), 64'd0);
      @(negedge clock);
    end
    // k counts negedges after the accept edge; 10 have already elapsed.
    seen = 10;
    while (!done && seen < LAT + 10) begin
      @(negedge clock);
      seen++;
    end
    chk("busy_latency", 64'(seen), 64'(LAT));
    chk("busy_first_result", 64'(bcd_out), 64'h0000_0042);
    chk("busy_ready_back", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("second_accepted", 64'(in_ready), 64'd0);
    wait_done(7);

    // Reset mid-conversion discards the partial result.
    @(negedge clock);
    start(55_555_555);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_bcd", 64'(bcd_out), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    chk("midrst_bcd_after", 64'(bcd_out), 64'd0);
    convert(1);

    // Random back-to-back at maximum throughput.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom_range(99_999_990, 100_000_010);
        default: v = $urandom_range(0, (1 << BIN_W) - 1);
      endcase
      convert(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
